// File: rtl/round_judge.sv
// Game-round sequencer: shows an LFSR-driven direction prompt, times the answer window,
// judges the key press and emits one held-high point or life pulse per round.
module round_judge #(
   parameter int WINDOW_CYCLES = 50_000_000,
   parameter int PULSE_CYCLES  = 2,
   parameter int GAP_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       key_valid,
   input  logic [1:0] key_dir,
   input  logic       dead,
   output logic       prompt_valid,
   output logic [1:0] prompt_dir,
   output logic       prompt_not,
   output logic       point_incr,
   output logic       life_incr,
   output logic [7:0] round_cnt,
   output logic       game_over,
   output logic [2:0] state_dbg,
   output logic [7:0] lfsr_dbg
);

   // Handshake: key_valid is a one-cycle strobe qualifying key_dir; there is no
   // ready, a strobe is consumed only while a prompt is showing (WAIT) and dropped otherwise.

   localparam int TW   = $clog2(WINDOW_CYCLES + 1);
   localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [TW-1:0] TIMER_LOAD = TW'(WINDOW_CYCLES);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PROMPT = 3'd1,
      S_WAIT   = 3'd2,
      S_HIT    = 3'd3,
      S_MISS   = 3'd4,
      S_GAP    = 3'd5,
      S_OVER   = 3'd6
   } state_t;

   state_t          state, state_next;
   logic [7:0]      lfsr;
   logic [7:0]      lfsr_next;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   cnt;
   logic            key_hit;

   assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   // A matching key wins a plain round and loses a NOT round.
   assign key_hit   = (key_dir == prompt_dir) ^ prompt_not;
   assign state_dbg = state;
   assign lfsr_dbg  = lfsr;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_PROMPT;
         S_PROMPT: state_next = S_WAIT;
         S_WAIT: begin
            // A key in the last window cycle takes precedence over the timeout.
            if (key_valid)               state_next = key_hit ? S_HIT : S_MISS;
            else if (timer == TIMER_ONE) state_next = prompt_not ? S_HIT : S_MISS;
         end
         S_HIT, S_MISS: if (cnt == PULSE_LAST) state_next = S_GAP;
         S_GAP:    if (cnt == GAP_LAST) state_next = dead ? S_OVER : S_PROMPT;
         S_OVER:   state_next = S_OVER;
         default:  state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lfsr         <= 8'hA5;
         timer        <= '0;
         cnt          <= '0;
         prompt_valid <= 1'b0;
         prompt_dir   <= 2'b00;
         prompt_not   <= 1'b0;
         point_incr   <= 1'b0;
         life_incr    <= 1'b0;
         round_cnt    <= 8'd0;
         game_over    <= 1'b0;
      end else begin
         prompt_valid <= (state_next == S_WAIT);
         point_incr   <= (state_next == S_HIT);
         life_incr    <= (state_next == S_MISS);
         game_over    <= (state_next == S_OVER);

         if (state == S_PROMPT) begin
            lfsr       <= lfsr_next;
            prompt_dir <= lfsr_next[1:0];
            prompt_not <= lfsr_next[2];
            round_cnt  <= round_cnt + 8'd1;
            timer      <= TIMER_LOAD;
         end else if (state == S_WAIT) begin
            timer <= timer - TIMER_ONE;
         end

         // cnt measures time spent in the pulse and gap states.
         if (state_next != state)
            cnt <= '0;
         else if (state == S_HIT || state == S_MISS || state == S_GAP)
            cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge: scripted and random rounds checked cycle by cycle against a
// prompt/verdict model built from the game rules.
module tb_round_judge;

   localparam int W = 8;
   localparam int P = 2;
   localparam int G = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       key_valid = 1'b0;
   logic [1:0] key_dir = 2'b00;
   logic       dead = 1'b0;
   logic       prompt_valid;
   logic [1:0] prompt_dir;
   logic       prompt_not;
   logic       point_incr;
   logic       life_incr;
   logic [7:0] round_cnt;
   logic       game_over;
   logic [2:0] state_dbg;
   logic [7:0] lfsr_dbg;

   int total = 0;
   int bad = 0;

   // model state
   logic [7:0] mdl_lfsr;
   logic [7:0] mdl_rounds;
   logic [1:0] exp_q[$];
   bit         last_hit;

   round_judge #(.WINDOW_CYCLES(W), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .key_valid(key_valid),
      .key_dir(key_dir), .dead(dead), .prompt_valid(prompt_valid),
      .prompt_dir(prompt_dir), .prompt_not(prompt_not), .point_incr(point_incr),
      .life_incr(life_incr), .round_cnt(round_cnt), .game_over(game_over),
      .state_dbg(state_dbg), .lfsr_dbg(lfsr_dbg)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #800_000;
      $display("FAIL watchdog: run exceeded time limit total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Taps at bits 7,5,4,3 folded in as a parity of the masked value.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic [7:0] m;
      m = v & 8'b1011_1000;
      return {v[6:0], ^m};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; start = 1'b0; key_valid = 1'b0; dead = 1'b0; key_dir = 2'b00;
      tick(); tick();
      reset_n = 1'b1;
      mdl_lfsr = 8'hA5;
      mdl_rounds = 8'd0;
      exp_q.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (state_dbg !== 3'd1 || prompt_valid !== 1'b0) begin
         bad++; $display("FAIL start_to_prompt: state=%0d prompt_valid=%b want state=1 prompt_valid=0", state_dbg, prompt_valid);
      end
   endtask

   // Plays one round starting in the PROMPT cycle; returns in the following PROMPT/OVER cycle.
   task automatic play_round(input bit give_key, input int key_at, input logic [1:0] kdir,
                             input bit dead_in, input string tag);
      logic [1:0] e_dir;
      logic       e_not;
      logic [1:0] e_pulse;
      bit         e_hit;
      bit         judged;
      mdl_lfsr   = lfsr_step(mdl_lfsr);
      mdl_rounds = mdl_rounds + 8'd1;
      e_dir = mdl_lfsr[1:0];
      e_not = mdl_lfsr[2];
      e_hit = 1'b0;
      judged = 1'b0;
      tick();
      total++;
      if (prompt_dir !== e_dir || prompt_not !== e_not || round_cnt !== mdl_rounds || lfsr_dbg !== mdl_lfsr) begin
         bad++; $display("FAIL %s prompt: dir=%b not=%b cnt=%0d lfsr=%h want dir=%b not=%b cnt=%0d lfsr=%h",
                         tag, prompt_dir, prompt_not, round_cnt, lfsr_dbg, e_dir, e_not, mdl_rounds, mdl_lfsr);
      end
      for (int i = 1; i <= W && !judged; i++) begin
         total++;
         if ({prompt_valid, point_incr, life_incr} !== 3'b100) begin
            bad++; $display("FAIL %s wait%0d: pv/pi/li=%b want 100", tag, i, {prompt_valid, point_incr, life_incr});
         end
         start = 1'($urandom_range(0, 1));
         dead  = 1'($urandom_range(0, 1));
         if (give_key && i == key_at) begin
            key_valid = 1'b1; key_dir = kdir;
            e_hit = (kdir == e_dir) != e_not;
            judged = 1'b1;
         end else begin
            key_valid = 1'b0; key_dir = 2'($urandom_range(0, 3));
         end
         tick();
         key_valid = 1'b0;
      end
      if (!judged) e_hit = e_not;
      last_hit = e_hit;
      exp_q.push_back({e_hit, !e_hit});
      e_pulse = 2'b00;
      for (int p = 0; p < P; p++) begin
         if (p == 0) e_pulse = exp_q.pop_front();
         total++;
         if ({prompt_valid, point_incr, life_incr} !== {1'b0, e_pulse}) begin
            bad++; $display("FAIL %s pulse%0d: pv/pi/li=%b want %b", tag, p, {prompt_valid, point_incr, life_incr}, {1'b0, e_pulse});
         end
         key_valid = 1'($urandom_range(0, 1)); key_dir = 2'($urandom_range(0, 3));
         start = 1'($urandom_range(0, 1)); dead = 1'($urandom_range(0, 1));
         tick();
      end
      for (int g = 1; g <= G; g++) begin
         total++;
         if ({prompt_valid, point_incr, life_incr} !== 3'b000 || prompt_dir !== e_dir || prompt_not !== e_not) begin
            bad++; $display("FAIL %s gap%0d: pv/pi/li=%b dir=%b not=%b want 000 dir=%b not=%b",
                            tag, g, {prompt_valid, point_incr, life_incr}, prompt_dir, prompt_not, e_dir, e_not);
         end
         key_valid = 1'($urandom_range(0, 1)); key_dir = 2'($urandom_range(0, 3));
         start = 1'($urandom_range(0, 1));
         dead = (g == G) ? dead_in : 1'($urandom_range(0, 1));
         tick();
      end
      key_valid = 1'b0; start = 1'b0; dead = 1'b0;
      total++;
      if (state_dbg !== (dead_in ? 3'd6 : 3'd1) || game_over !== dead_in) begin
         bad++; $display("FAIL %s after_gap: state=%0d game_over=%b want state=%0d game_over=%b",
                         tag, state_dbg, game_over, dead_in ? 6 : 1, dead_in);
      end
   endtask

   // scenario tasks
   task automatic test_reset();
      do_reset();
      total++;
      if ({prompt_valid, prompt_dir, prompt_not, point_incr, life_incr, game_over} !== 7'd0 ||
          round_cnt !== 8'd0 || state_dbg !== 3'd0 || lfsr_dbg !== 8'hA5) begin
         bad++; $display("FAIL reset_values: pv=%b dir=%b not=%b pi=%b li=%b go=%b cnt=%0d st=%0d lfsr=%h want all 0, lfsr a5",
                         prompt_valid, prompt_dir, prompt_not, point_incr, life_incr, game_over, round_cnt, state_dbg, lfsr_dbg);
      end
      // key and dead are ignored while idle
      key_valid = 1'b1; dead = 1'b1;
      tick(); tick();
      key_valid = 1'b0; dead = 1'b0;
      total++;
      if (state_dbg !== 3'd0 || round_cnt !== 8'd0) begin
         bad++; $display("FAIL idle_hold: state=%0d cnt=%0d want 0 0", state_dbg, round_cnt);
      end
   endtask

   task automatic test_first_round_hit();
      do_reset(); do_start();
      play_round(1'b1, 3, 2'b10, 1'b0, "first_hit");
      total++;
      if (lfsr_dbg !== 8'h4A || prompt_dir !== 2'b10 || prompt_not !== 1'b0 || round_cnt !== 8'd1) begin
         bad++; $display("FAIL first_round_consts: lfsr=%h dir=%b not=%b cnt=%0d want 4a 10 0 1", lfsr_dbg, prompt_dir, prompt_not, round_cnt);
      end
      play_round(1'b0, 1, 2'b00, 1'b0, "second_round");
   endtask

   task automatic test_timeout_miss();
      do_reset(); do_start();
      play_round(1'b0, 1, 2'b00, 1'b0, "timeout");
   endtask

   task automatic test_late_key();
      do_reset(); do_start();
      play_round(1'b1, W, 2'b01, 1'b0, "late_key");
   endtask

   task automatic test_not_rounds();
      logic [7:0] peek;
      bit done1 = 1'b0;
      bit done2 = 1'b0;
      do_reset(); do_start();
      for (int r = 0; r < 100 && !done2; r++) begin
         peek = lfsr_step(mdl_lfsr);
         if (peek[2] && !done1) begin
            play_round(1'b0, 1, 2'b00, 1'b0, "not_timeout");
            done1 = 1'b1;
         end else if (peek[2]) begin
            play_round(1'b1, $urandom_range(1, W), peek[1:0], 1'b0, "not_match");
            done2 = 1'b1;
         end else begin
            play_round(1'($urandom_range(0, 1)), $urandom_range(1, W), 2'($urandom_range(0, 3)), 1'b0, "plain_rand");
         end
      end
      total++;
      if (!done2) begin
         bad++; $display("FAIL not_rounds_seen: found=%b want 1", done2);
      end
   endtask

   task automatic test_game_over();
      logic [7:0] peek;
      logic [7:0] cnt_hold;
      int lives = 3;
      do_reset(); do_start();
      for (int r = 0; r < 3; r++) begin
         peek = lfsr_step(mdl_lfsr);
         lives--;
         // choose the losing answer for this round's prompt
         play_round(1'b1, $urandom_range(1, W), peek[2] ? peek[1:0] : (peek[1:0] ^ 2'b01),
                    lives == 0, "lose_life");
      end
      cnt_hold = round_cnt;
      for (int c = 0; c < 20; c++) begin
         start = 1'($urandom_range(0, 1)); key_valid = 1'($urandom_range(0, 1));
         key_dir = 2'($urandom_range(0, 3)); dead = 1'($urandom_range(0, 1));
         tick();
         total++;
         if ({game_over, prompt_valid, point_incr, life_incr} !== 4'b1000 || round_cnt !== cnt_hold) begin
            bad++; $display("FAIL over_sticky%0d: go/pv/pi/li=%b cnt=%0d want 1000 cnt=%0d",
                            c, {game_over, prompt_valid, point_incr, life_incr}, round_cnt, cnt_hold);
         end
      end
      start = 1'b0; key_valid = 1'b0; dead = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      do_reset(); do_start();
      tick();
      key_valid = 1'b1; key_dir = 2'b10;
      tick();
      key_valid = 1'b0;
      total++;
      if (point_incr !== 1'b1) begin
         bad++; $display("FAIL hit_before_reset: point_incr=%b want 1", point_incr);
      end
      reset_n = 1'b0;
      tick();
      total++;
      if (point_incr !== 1'b0 || life_incr !== 1'b0 || round_cnt !== 8'd0 || lfsr_dbg !== 8'hA5 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL reset_mid_pulse: pi=%b li=%b cnt=%0d lfsr=%h st=%0d want 0 0 0 a5 0",
                         point_incr, life_incr, round_cnt, lfsr_dbg, state_dbg);
      end
      reset_n = 1'b1;
      tick();
      total++;
      if (point_incr !== 1'b0 || state_dbg !== 3'd0) begin
         bad++; $display("FAIL no_pulse_after_reset: pi=%b st=%0d want 0 0", point_incr, state_dbg);
      end
   endtask

   task automatic test_back_to_back_wrap();
      do_reset(); do_start();
      for (int r = 0; r < 256; r++)
         play_round(1'($urandom_range(0, 1)), $urandom_range(1, W), 2'($urandom_range(0, 3)), 1'b0, "wrap");
      total++;
      if (round_cnt !== 8'd0) begin
         bad++; $display("FAIL round_wrap: cnt=%0d want 0", round_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_first_round_hit();
      test_timeout_miss();
      test_late_key();
      test_not_rounds();
      test_game_over();
      test_reset_mid_pulse();
      test_back_to_back_wrap();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/round_judge.md
# round_judge

Game-round sequencer that drives the increment side of the score and lives counters. It issues a pseudo-random direction prompt, with an optional "NOT" inversion, and times the player's response window. It judges the key press and emits a held-high `point_incr` or `life_incr` pulse to the counter blocks, which count on the pulse's release. It samples the lives block's `dead` flag between rounds and ends the game.

## Interface
- `WINDOW_CYCLES`, default 50_000_000: response window length in clk cycles; must be ≥ 1.
- `PULSE_CYCLES`, default 2: cycles each incr output is held high; must be ≥ 1.
- `GAP_CYCLES`, default 4: inter-round idle cycles; must be ≥ 4 so that `dead` settles.
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin game; sampled only in IDLE.
- `key_valid` in 1: single-cycle key-press strobe.
- `key_dir` in 2: pressed direction, valid with `key_valid`.
- `dead` in 1: from the lives counter; 1 = no lives remain.
- `prompt_valid` out 1: a prompt is showing, high during WAIT.
- `prompt_dir` out 2: prompted direction.
- `prompt_not` out 1: 1 = "NOT `prompt_dir`" round.
- `point_incr` out 1: held high `PULSE_CYCLES` cycles on a correct response.
- `life_incr` out 1: held high `PULSE_CYCLES` cycles on a wrong response.
- `round_cnt` out 8: rounds started; wraps from 255 to 0.
- `game_over` out 1: sticky end-of-game flag.

## Operation
- States: IDLE, PROMPT, WAIT, HIT, MISS, GAP, OVER.
- IDLE: `start`=1 → PROMPT.
- PROMPT (1 cycle):
  - LFSR advances one step.
  - `prompt_dir` ← next[1:0]; `prompt_not` ← next[2].
  - `round_cnt` += 1.
  - Timer ← `WINDOW_CYCLES`.
  - → WAIT.
- LFSR: 8-bit, seed 8'hA5 on reset; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances only in PROMPT.
- WAIT: timer decrements each cycle. Judging:
  - `prompt_not`=0: `key_valid` with `key_dir`==`prompt_dir` → HIT. Mismatched key → MISS. Timeout → MISS.
  - `prompt_not`=1: key with `key_dir`==`prompt_dir` → MISS. Mismatched key → HIT. Timeout → HIT.
- Timeout occurs when the timer reaches 0 with no key, i.e. after `WINDOW_CYCLES` WAIT cycles.
- If `key_valid` arrives in the final WAIT cycle, the key takes precedence over the timeout.
- HIT / MISS: `point_incr` (HIT) or `life_incr` (MISS) is held high for exactly `PULSE_CYCLES` cycles, then → GAP.
- GAP: all pulse outputs are low for `GAP_CYCLES` cycles. In the last GAP cycle, `dead`=1 → OVER, else → PROMPT.
- OVER: `game_over`=1. Terminal until `reset_n`.
- Ignored inputs:
  - `key_valid` outside WAIT.
  - `start` outside IDLE.
  - `dead` outside the last GAP cycle.
- At most one of `point_incr` / `life_incr` is high at any time; each round yields exactly one pulse.

## Timing
- Reset values:
  - State IDLE, LFSR 8'hA5, timer 0.
  - `prompt_valid`, `prompt_dir`, `prompt_not`, `point_incr`, `life_incr`, `game_over` all 0.
  - `round_cnt` 0.
- All outputs are registered.
- `start` sampled at edge N → PROMPT in cycle N+1 → `prompt_valid`=1 from N+2.
- `prompt_dir` / `prompt_not` are stable from WAIT entry through the end of GAP.
- `key_valid` at WAIT edge K → `prompt_valid`=0 and incr=1 from K+1, for `PULSE_CYCLES` cycles.
- Round length, key case: 1 + (cycles in WAIT) + `PULSE_CYCLES` + `GAP_CYCLES`.
- Downstream counters register the count about 2 cycles after the incr falling edge. `dead` follows 1 cycle later, which is why `GAP_CYCLES` ≥ 4.
- `reset_n`=0 in any state, including mid-pulse: the next edge forces reset values; no pulse is completed.

## Test plan
- Reset, then `start`; bench params `WINDOW_CYCLES`=8, `PULSE_CYCLES`=2, `GAP_CYCLES`=4 → LFSR=8'h4A, `prompt_dir`=2'b10, `prompt_not`=0, `round_cnt`=1, `prompt_valid` high 2 cycles after `start`.
- Round 1: `key_valid` with `key_dir`=2'b10 on the 3rd WAIT cycle → `point_incr` high exactly 2 cycles, `life_incr` 0, then 4 GAP cycles, then PROMPT with `round_cnt`=2.
- Round 1 with no key for 8 cycles → `life_incr` high exactly 2 cycles. With key 2'b01 on the 8th WAIT cycle → `life_incr`, not a timeout double-count.
- Force a `prompt_not`=1 round; no key → `point_incr`. Key equal to `prompt_dir` → `life_incr`.
- Connect to the lives block and miss 3 rounds → `game_over`=1 after the third GAP, no further pulses. `start` and `key_valid` are ignored until `reset_n`.
- Assert `reset_n`=0 during the 1st HIT cycle → next cycle `point_incr`=0, `round_cnt`=0, LFSR=8'hA5, IDLE. 256 rounds → `round_cnt` wraps to 0.
